// File: rtl/intr_request_ctrl.sv
// Interrupt requester: synchronises and edge-detects irq lines into a pending register,
// issues one request at a time to the control unit and follows the ISR via in_service.
module intr_request_ctrl #(
   parameter int                 NUM_SRC     = 4,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_SRC-1:0] MASK_RST    = 4'hF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC-1:0]         irq_in,
   input  logic                       mask_we,
   input  logic [NUM_SRC-1:0]         mask_wdata,
   input  logic                       int_clr,
   input  logic                       in_service,
   output logic                       intr,
   output logic [$clog2(NUM_SRC)-1:0] irq_id,
   output logic [NUM_SRC-1:0]         pending,
   output logic [NUM_SRC-1:0]         mask,
   output logic                       busy,
   output logic [1:0]                 state_dbg
);

   localparam int ID_W = $clog2(NUM_SRC);

   // Handshake: intr stays high from IDLE->REQ until the cycle int_clr is seen in REQ;
   // in_service high moves WAIT->SERV, in_service low (RTI) moves SERV->IDLE.
   typedef enum logic [1:0] {IDLE, REQ, WAIT, SERV} state_t;

   state_t              state_q, state_d;
   logic [NUM_SRC-1:0]  sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0]  sync_d;
   logic [NUM_SRC-1:0]  irq_evt;
   logic [NUM_SRC-1:0]  elig;
   logic [NUM_SRC-1:0]  clr_vec;
   logic [ID_W-1:0]     win_id;
   logic                win_vld;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign irq_evt = sync_q[SYNC_STAGES-1] & ~sync_d;
   assign elig    = pending & mask;

   // Fixed priority: lowest eligible index wins.
   always_comb begin
      win_id  = '0;
      win_vld = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_id  = ID_W'(i);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      clr_vec = '0;
      case (state_q)
         IDLE: if (win_vld && !in_service) state_d = REQ;
         REQ: begin
            if (int_clr) begin
               state_d         = WAIT;
               clr_vec[irq_id] = 1'b1;
            end
         end
         WAIT: if (in_service) state_d = SERV;
         SERV: if (!in_service) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         intr    <= 1'b0;
         irq_id  <= '0;
         pending <= '0;
         mask    <= MASK_RST;
         sync_d  <= '0;
      end else begin
         state_q <= state_d;
         intr    <= (state_d == REQ);
         if (state_q == IDLE && state_d == REQ) irq_id <= win_id;
         // A fresh edge in the clearing cycle re-sets the bit being retired.
         pending <= (pending & ~clr_vec) | irq_evt;
         if (mask_we) mask <= mask_wdata;
         sync_d  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Directed bench for intr_request_ctrl: behavioural model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_intr_request_ctrl;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq_in;
   logic         mask_we;
   logic [N-1:0] mask_wdata;
   logic         int_clr;
   logic         in_service;
   logic         intr;
   logic [1:0]   irq_id;
   logic [N-1:0] pending;
   logic [N-1:0] mask;
   logic         busy;
   logic [1:0]   state_dbg;

   int checks = 0;
   int errors = 0;

   intr_request_ctrl #(.NUM_SRC(N), .SYNC_STAGES(2), .MASK_RST(4'hF)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .int_clr(int_clr), .in_service(in_service), .intr(intr), .irq_id(irq_id),
      .pending(pending), .mask(mask), .busy(busy), .state_dbg(state_dbg)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Behavioural model: irq samples delayed through a history line, event = 0->1 seen
   // three samples back; one request at a time following the CU handshake phases.
   localparam int PH_IDLE = 0, PH_REQ = 1, PH_ENTRY = 2, PH_ISR = 3;

   logic [N-1:0] h1, h2, h3, m_pend, m_mask, ev, el, clr;
   logic         m_intr;
   logic [1:0]   m_id;
   int           m_phase;
   bit           m_valid = 1'b0;

   function automatic logic [1:0] lowest(input logic [N-1:0] v);
      lowest = 2'd0;
      for (int i = N - 1; i >= 0; i--) if (v[i]) lowest = 2'(i);
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         h1 = '0; h2 = '0; h3 = '0;
         m_pend = '0; m_mask = 4'hF; m_intr = 1'b0; m_id = 2'd0;
         m_phase = PH_IDLE; m_valid = 1'b1;
      end else begin
         ev  = h2 & ~h3;
         el  = m_pend & m_mask;
         clr = '0;
         if (m_phase == PH_IDLE) begin
            if (el != 0 && !in_service) begin
               m_phase = PH_REQ; m_id = lowest(el); m_intr = 1'b1;
            end
         end else if (m_phase == PH_REQ) begin
            if (int_clr) begin
               clr[m_id] = 1'b1; m_phase = PH_ENTRY; m_intr = 1'b0;
            end
         end else if (m_phase == PH_ENTRY) begin
            if (in_service) m_phase = PH_ISR;
         end else begin
            if (!in_service) m_phase = PH_IDLE;
         end
         m_pend = (m_pend & ~clr) | ev;
         if (mask_we) m_mask = mask_wdata;
         h3 = h2; h2 = h1; h1 = irq_in;
      end
   end

   // Scoreboard compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         chk("intr", intr, m_intr);
         chk("irq_id", irq_id, m_id);
         chk("pending", pending, m_pend);
         chk("mask", mask, m_mask);
         chk("busy", busy, m_phase != PH_IDLE);
      end
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic service();
      int_clr = 1'b1;
      tick(1);
      int_clr    = 1'b0;
      in_service = 1'b1;
      tick(3);
      in_service = 1'b0;
      tick(1);
   endtask

   initial begin
      rst = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
      int_clr = 1'b0; in_service = 1'b0;
      tick(2);
      chk("rst_intr", intr, 0);
      chk("rst_pending", pending, 0);
      chk("rst_mask", mask, 4'hF);
      chk("rst_busy", busy, 0);
      rst = 1'b1;
      tick(1);

      // 1: single source, 3-clock latency to pending, request next clock
      irq_in = 4'b0001;
      tick(2);
      chk("t1_pend_early", pending, 4'b0000);
      tick(1);
      chk("t1_pend", pending, 4'b0001);
      chk("t1_intr_low", intr, 0);
      tick(1);
      chk("t1_intr", intr, 1);
      chk("t1_id", irq_id, 0);
      int_clr = 1'b1;
      tick(1);
      int_clr = 1'b0;
      chk("t1_intr_clr", intr, 0);
      chk("t1_pend_clr", pending, 4'b0000);
      chk("t1_busy_wait", busy, 1);

      // 2: ISR entry, second irq during SERV held off until after RTI
      in_service = 1'b1;
      tick(1);
      chk("t2_busy_serv", busy, 1);
      irq_in = 4'b0011;
      tick(4);
      chk("t2_pend", pending, 4'b0010);
      chk("t2_intr_held", intr, 0);
      in_service = 1'b0;
      tick(1);
      chk("t2_idle", busy, 0);
      chk("t2_intr_gap", intr, 0);
      tick(1);
      chk("t2_intr", intr, 1);
      chk("t2_id", irq_id, 1);
      service();

      // 3: simultaneous 2 and 3 -> 2 first, then 3
      irq_in = 4'b1111;
      tick(3);
      chk("t3_pend", pending, 4'b1100);
      tick(1);
      chk("t3_id2", irq_id, 2);
      service();
      chk("t3_idle", busy, 0);
      tick(1);
      chk("t3_intr", intr, 1);
      chk("t3_id3", irq_id, 3);
      service();

      // 4: masked source latches but does not request; stray int_clr ignored
      irq_in = '0; mask_we = 1'b1; mask_wdata = 4'b1110;
      tick(1);
      mask_we = 1'b0;
      chk("t4_mask", mask, 4'b1110);
      irq_in = 4'b0001;
      tick(5);
      chk("t4_pend", pending, 4'b0001);
      chk("t4_intr_masked", intr, 0);
      int_clr = 1'b1;
      tick(1);
      int_clr = 1'b0;
      chk("t4_clr_ignored", pending, 4'b0001);
      chk("t4_busy", busy, 0);
      mask_we = 1'b1; mask_wdata = 4'hF;
      tick(1);
      mask_we = 1'b0;
      chk("t4_intr_unmask_gap", intr, 0);
      tick(1);
      chk("t4_intr", intr, 1);
      chk("t4_id", irq_id, 0);
      service();

      // 5: re-edge of id 1 lands in its clearing cycle -> stays pending
      irq_in = '0;
      tick(1);
      irq_in = 4'b0010;
      tick(4);
      chk("t5_intr", intr, 1);
      chk("t5_id", irq_id, 1);
      irq_in = '0;
      tick(1);
      irq_in = 4'b0010;
      tick(2);
      int_clr = 1'b1;
      tick(1);
      int_clr = 1'b0;
      chk("t5_pend_kept", pending, 4'b0010);
      chk("t5_intr_clr", intr, 0);
      in_service = 1'b1;
      tick(2);
      in_service = 1'b0;
      tick(1);
      chk("t5_idle", busy, 0);
      tick(1);
      chk("t5_rereq", intr, 1);
      chk("t5_reid", irq_id, 1);

      // 6: reset mid-request
      mask_we = 1'b1; mask_wdata = 4'b0011;
      tick(1);
      mask_we = 1'b0;
      chk("t6_mask_w", mask, 4'b0011);
      rst = 1'b0;
      tick(1);
      chk("t6_intr", intr, 0);
      chk("t6_pend", pending, 4'b0000);
      chk("t6_mask", mask, 4'hF);
      chk("t6_busy", busy, 0);
      rst = 1'b1; irq_in = '0;
      tick(4);
      chk("t6_quiet", intr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
